// File: rtl/bet_ledger_if.sv
// Bet-ledger bus: bet/undo/spin strobes from the keyboard side, the ledger contents
// and status toward the register file.
interface bet_ledger_if #(
  parameter int NUM_BETS = 12,
  parameter int OPCODE_W = 6,
  parameter int COLOR_W  = 2
);
  localparam int ENTRY_W = COLOR_W + OPCODE_W;
  localparam int CNT_W   = $clog2(NUM_BETS + 1);

  logic                        bet_valid;
  logic [OPCODE_W-1:0]         bet_opcode;
  logic [COLOR_W-1:0]          bet_color;
  logic                        undo;
  logic                        spin_req;
  logic                        spin_done;
  logic [NUM_BETS*ENTRY_W-1:0] bets_flat;
  logic [CNT_W-1:0]            bet_count;
  logic                        full;
  logic                        locked;
  logic                        spin_start;
  logic                        rejected;

  modport master (
    output bet_valid, bet_opcode, bet_color, undo, spin_req, spin_done,
    input  bets_flat, bet_count, full, locked, spin_start, rejected
  );

  modport slave (
    input  bet_valid, bet_opcode, bet_color, undo, spin_req, spin_done,
    output bets_flat, bet_count, full, locked, spin_start, rejected
  );
endinterface

// File: rtl/bet_ledger.sv
// Bet-capture ledger: stores bets in arrival order with undo, and locks betting through
// the OPEN -> SPIN -> HOLD -> CLEAR spin lifecycle.
module bet_ledger #(
  parameter int                  NUM_BETS    = 12,
  parameter int                  OPCODE_W    = 6,
  parameter int                  COLOR_W     = 2,
  parameter logic [OPCODE_W-1:0] NOKEY_CODE  = 6'h3F,
  parameter int                  HOLD_CYCLES = 1024
) (
  input logic         clock,
  input logic         reset,
  bet_ledger_if.slave bus
);
  localparam int ENTRY_W = COLOR_W + OPCODE_W;
  localparam int CNT_W   = $clog2(NUM_BETS + 1);
  localparam int TMR_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_BETS);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    SPIN  = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [NUM_BETS-1:0][ENTRY_W-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [TMR_W-1:0]                 timer_q, timer_d;
  logic                             full_q, full_d;
  logic                             locked_q, locked_d;
  logic                             spinStart_q, spinStart_d;
  logic                             rejected_q, rejected_d;

  logic             anyStrobe;
  logic             betOk;
  logic [CNT_W-1:0] lastIdx;

  assign anyStrobe = bus.bet_valid | bus.undo | bus.spin_req;
  assign betOk     = (count_q != CNT_FULL) && (bus.bet_opcode != NOKEY_CODE) &&
                     (bus.bet_color != '0);
  assign lastIdx   = count_q - CNT_ONE;

  // One action per cycle in OPEN (spin > undo > bet); any dropped strobe pulses rejected once.
  always_comb begin
    state_d     = state_q;
    entries_d   = entries_q;
    count_d     = count_q;
    timer_d     = timer_q;
    spinStart_d = 1'b0;
    rejected_d  = 1'b0;
    case (state_q)
      OPEN: begin
        if (bus.spin_req) begin
          if (count_q != '0) begin
            state_d     = SPIN;
            spinStart_d = 1'b1;
            rejected_d  = bus.undo | bus.bet_valid;
          end else begin
            rejected_d  = 1'b1;
          end
        end else if (bus.undo) begin
          if (count_q != '0) begin
            for (int i = 0; i < NUM_BETS; i++) begin
              if (CNT_W'(i) == lastIdx) entries_d[i] = '0;
            end
            count_d    = lastIdx;
            rejected_d = bus.bet_valid;
          end else begin
            rejected_d = 1'b1;
          end
        end else if (bus.bet_valid) begin
          if (betOk) begin
            for (int i = 0; i < NUM_BETS; i++) begin
              if (CNT_W'(i) == count_q) entries_d[i] = {bus.bet_color, bus.bet_opcode};
            end
            count_d = count_q + CNT_ONE;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      SPIN: begin
        rejected_d = anyStrobe;
        if (bus.spin_done) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Wiping here keeps the bets visible for exactly HOLD_CYCLES cycles.
        rejected_d = anyStrobe;
        if (timer_q == '0) begin
          state_d   = CLEAR;
          entries_d = '0;
          count_d   = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      CLEAR: begin
        rejected_d = anyStrobe;
        state_d    = OPEN;
      end
      default: state_d = OPEN;
    endcase
    full_d   = (count_d == CNT_FULL);
    locked_d = (state_d != OPEN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OPEN;
      entries_q   <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      full_q      <= 1'b0;
      locked_q    <= 1'b0;
      spinStart_q <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entries_q   <= entries_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      full_q      <= full_d;
      locked_q    <= locked_d;
      spinStart_q <= spinStart_d;
      rejected_q  <= rejected_d;
    end
  end

  assign bus.bets_flat  = entries_q;
  assign bus.bet_count  = count_q;
  assign bus.full       = full_q;
  assign bus.locked     = locked_q;
  assign bus.spin_start = spinStart_q;
  assign bus.rejected   = rejected_q;
endmodule

// File: tb/tb_bet_ledger.sv
// Scoreboard bench for bet_ledger: a queue-based ledger model predicts every cycle's outputs,
// a monitor compares them against the DUT one cycle at a time.
module tb_bet_ledger;
  localparam int NB   = 12;
  localparam int HOLD = 4;

  typedef struct packed {
    logic [NB*8-1:0] flat;
    logic [3:0]      cnt;
    logic            full;
    logic            locked;
    logic            ss;
    logic            rej;
  } exp_t;

  logic clock;
  logic reset;

  bet_ledger_if #(.NUM_BETS(NB), .OPCODE_W(6), .COLOR_W(2)) bus ();

  bet_ledger #(
    .NUM_BETS(NB), .OPCODE_W(6), .COLOR_W(2), .NOKEY_CODE(6'h3F), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  // Reference model: the ledger as a queue of bytes, the lifecycle as a phase number.
  logic [7:0] ledger[$];
  int         phase = 0;
  int         holdLeft = 0;
  logic       mSpinStart = 1'b0;
  logic       mRej = 1'b0;

  function automatic exp_t buildExp();
    exp_t e;
    e = '0;
    for (int i = 0; i < ledger.size(); i++) e.flat[i*8 +: 8] = ledger[i];
    e.cnt    = 4'(ledger.size());
    e.full   = (ledger.size() == NB);
    e.locked = (phase != 0);
    e.ss     = mSpinStart;
    e.rej    = mRej;
    return e;
  endfunction

  function automatic exp_t sampleDut();
    exp_t a;
    a.flat   = bus.bets_flat;
    a.cnt    = bus.bet_count;
    a.full   = bus.full;
    a.locked = bus.locked;
    a.ss     = bus.spin_start;
    a.rej    = bus.rejected;
    return a;
  endfunction

  task automatic modelStep(input logic bv, un, sr, sd, input logic [5:0] op,
                           input logic [1:0] col);
    mSpinStart = 1'b0;
    mRej       = 1'b0;
    case (phase)
      0: begin
        if (sr) begin
          if (ledger.size() > 0) begin
            phase = 1; mSpinStart = 1'b1; mRej = un | bv;
          end else mRej = 1'b1;
        end else if (un) begin
          if (ledger.size() > 0) begin
            void'(ledger.pop_back()); mRej = bv;
          end else mRej = 1'b1;
        end else if (bv) begin
          if (ledger.size() < NB && op != 6'h3F && col != 2'd0) ledger.push_back({col, op});
          else mRej = 1'b1;
        end
      end
      1: begin
        mRej = bv | un | sr;
        if (sd) begin phase = 2; holdLeft = HOLD; end
      end
      2: begin
        mRej = bv | un | sr;
        holdLeft--;
        if (holdLeft == 0) begin phase = 3; ledger.delete(); end
      end
      default: begin
        mRej  = bv | un | sr;
        phase = 0;
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input exp_t e, input exp_t a);
    testsRun++;
    if (a !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got cnt=%0d full=%0b locked=%0b ss=%0b rej=%0b flat=%h, want cnt=%0d full=%0b locked=%0b ss=%0b rej=%0b flat=%h",
               name, a.cnt, a.full, a.locked, a.ss, a.rej, a.flat,
               e.cnt, e.full, e.locked, e.ss, e.rej, e.flat);
    end
  endtask

  // Drives one cycle of strobes and queues the outputs the model predicts after the next edge.
  task automatic applyStimulus(input logic bv, un, sr, sd, input logic [5:0] op,
                               input logic [1:0] col);
    @(negedge clock);
    bus.bet_valid  = bv;
    bus.undo       = un;
    bus.spin_req   = sr;
    bus.spin_done  = sd;
    bus.bet_opcode = op;
    bus.bet_color  = col;
    modelStep(bv, un, sr, sd, op, col);
    expQ.push_back(buildExp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0);
  endtask

  task automatic bet(input logic [1:0] col, input logic [5:0] op);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, op, col);
  endtask

  // Monitor: one prediction is retired per clock edge that has one queued.
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("cycle%0d", cyc), e, sampleDut());
      end
    end
  end

  initial begin
    exp_t zeroExp;
    zeroExp = '0;
    reset = 1'b1;
    bus.bet_valid = 1'b0; bus.undo = 1'b0; bus.spin_req = 1'b0; bus.spin_done = 1'b0;
    bus.bet_opcode = 6'd0; bus.bet_color = 2'd0;
    repeat (3) @(negedge clock);
    checkOutput("resetState", zeroExp, sampleDut());
    reset = 1'b0;
    idle(1);

    bet(2'b01, 6'd5);
    bet(2'b10, 6'h12);
    bet(2'b11, 6'd20);
    idle(1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0);

    bet(2'b00, 6'd7);
    bet(2'b01, 6'h3F);
    for (int i = 0; i < 13; i++) bet(2'($urandom_range(1, 3)), 6'($urandom_range(0, 62)));
    idle(1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd9, 2'd1);
    bet(2'b01, 6'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 2'd0);
    bet(2'b10, 6'd4);
    idle(7);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 2'd0);
    bet(2'b01, 6'd1);
    bet(2'b10, 6'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 2'd0);
    idle(2);

    @(negedge clock);
    bus.bet_valid = 1'b0; bus.undo = 1'b0; bus.spin_req = 1'b0; bus.spin_done = 1'b0;
    #2 reset = 1'b1;
    #1 checkOutput("asyncResetInHold", zeroExp, sampleDut());
    ledger.delete();
    phase = 0;
    holdLeft = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    bet(2'b11, 6'd33);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      logic       bv, un, sr, sd;
      logic [5:0] op;
      bv = ($urandom_range(0, 99) < 50);
      un = ($urandom_range(0, 99) < 10);
      sr = ($urandom_range(0, 99) < 6);
      sd = ($urandom_range(0, 99) < 15);
      op = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      applyStimulus(bv, un, sr, sd, op, 2'($urandom_range(0, 3)));
    end
    idle(2);

    @(negedge clock);
    @(negedge clock);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d predictions left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
